// File: rtl/fnn_pkg.sv
// Shared types and helpers for the fully-connected network datapath.
package fnn_pkg;

    // Serializer FSM encoding: gather neuron outputs, then stream them out.
    typedef enum logic [0:0] {
        COLLECT = 1'b0,
        SHIFT   = 1'b1
    } ser_state_t;

    // Index counter width; never narrower than one bit so NUM_NEURONS=1 still works.
    function automatic int cnt_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/layer_output_serializer_if.sv
// Parallel-in / serial-out bus between two fully-connected layers.
// master drives neuron outputs and observes the stream; slave is the serializer.
interface layer_output_serializer_if #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
);
    logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data;
    logic [NUM_NEURONS-1:0]            in_valid;
    logic [DATA_WIDTH-1:0]             out_data;
    logic                              out_valid;
    logic                              busy;
    logic                              overrun;

    modport master (
        output in_data, in_valid,
        input  out_data, out_valid, busy, overrun
    );

    modport slave (
        input  in_data, in_valid,
        output out_data, out_valid, busy, overrun
    );
endinterface

// File: rtl/layer_output_serializer_capture.sv
// Per-neuron capture buffer with arrival flags and an indexed read port.
module layer_capture_bank
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16,
    parameter int CNT_W       = cnt_width(NUM_NEURONS)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_data_i,
    input  logic [NUM_NEURONS-1:0]            in_valid_i,
    input  logic                              capture_en_i,
    input  logic                              clear_i,
    input  logic [CNT_W-1:0]                  rd_idx_i,
    output logic                              all_got_o,
    output logic [DATA_WIDTH-1:0]             rd_data_o
);

    logic [NUM_NEURONS-1:0][DATA_WIDTH-1:0] buf_q;
    logic [NUM_NEURONS-1:0]                 got_q;
    logic [NUM_NEURONS-1:0]                 cap_mask;

    assign cap_mask = capture_en_i ? in_valid_i : '0;

    // All present once this cycle's arrivals are folded in, so the FSM can leave COLLECT immediately.
    assign all_got_o = &(got_q | cap_mask);

    // Arrival flags: cleared at frame end, sticky per neuron otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            got_q <= '0;
        end else if (clear_i) begin
            got_q <= '0;
        end else begin
            got_q <= got_q | cap_mask;
        end
    end

    // Data buffer: latest arrival wins; contents need no reset since got_q gates their use.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (cap_mask[i]) begin
                buf_q[i] <= in_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Read mux by stream index; written as a compare loop so any NUM_NEURONS indexes cleanly.
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (rd_idx_i == CNT_W'(i)) begin
                rd_data_o = buf_q[i];
            end
        end
    end

endmodule

// File: rtl/layer_output_serializer.sv
// Collects one layer's skewed neuron outputs, then broadcasts them one per cycle
// (neuron 0 first) as the next layer's input stream. All outputs are registered.
module layer_output_serializer
    import fnn_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    layer_output_serializer_if.slave  bus
);

    localparam int               CNT_W      = cnt_width(NUM_NEURONS);
    localparam logic [0:0]       ST_COLLECT = COLLECT;
    localparam logic [0:0]       ST_SHIFT   = SHIFT;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_NEURONS - 1);

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;
    logic                  busy_q, busy_d;
    logic                  overrun_q, overrun_d;

    logic                  capture_en;
    logic                  clear;
    logic                  all_got;
    logic [DATA_WIDTH-1:0] rd_data;

    layer_capture_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .DATA_WIDTH  (DATA_WIDTH),
        .CNT_W       (CNT_W)
    ) u_bank (
        .clk          (clk),
        .rst          (rst),
        .in_data_i    (bus.in_data),
        .in_valid_i   (bus.in_valid),
        .capture_en_i (capture_en),
        .clear_i      (clear),
        .rd_idx_i     (cnt_q),
        .all_got_o    (all_got),
        .rd_data_o    (rd_data)
    );

    // Next-state: capture until every neuron reported, then emit NUM_NEURONS back-to-back beats.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        busy_d      = 1'b0;
        overrun_d   = overrun_q;
        capture_en  = (state_q == ST_COLLECT);
        clear       = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (all_got) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                out_data_d  = rd_data;
                out_valid_d = 1'b1;
                busy_d      = 1'b1;
                // Arrivals while streaming would corrupt the frame; drop and flag them.
                if (|bus.in_valid) begin
                    overrun_d = 1'b1;
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_COLLECT;
                    cnt_d   = '0;
                    clear   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_COLLECT;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.overrun   = overrun_q;

endmodule
